// File: rtl/ctrl_pkg.sv
// Shared opcode map, ALU operation codes and sequencer state encoding for ctrl_seq.
package ctrl_pkg;

   localparam logic [3:0] OP_B    = 4'd0;
   localparam logic [3:0] OP_JEQ  = 4'd1;
   localparam logic [3:0] OP_JNE  = 4'd2;
   localparam logic [3:0] OP_JLT  = 4'd3;
   localparam logic [3:0] OP_JGE  = 4'd4;
   localparam logic [3:0] OP_ADD  = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_STR  = 4'd7;
   localparam logic [3:0] OP_LD   = 4'd8;
   localparam logic [3:0] OP_SUB  = 4'd9;
   localparam logic [3:0] OP_MOVF = 4'd10;
   localparam logic [3:0] OP_LSR  = 4'd11;
   localparam logic [3:0] OP_CMP  = 4'd12;
   localparam logic [3:0] OP_LSL  = 4'd13;
   localparam logic [3:0] OP_MOVI = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_XOR  = 3'd2,
      ALU_LSL  = 3'd3,
      ALU_LSR  = 3'd4,
      ALU_PASS = 3'd5
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_MEM_WAIT,
      ST_HALT
   } ctrl_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode; conditional jumps resolve against the registered flags.
// Opcode 1011 decodes as LSR when CTRL_SEQ_LSR_EN is defined, otherwise as a NOP.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic [OPW-1:0] opcode_i,
   input  logic           flag_z_i,
   input  logic           flag_n_i,
   output logic           uncond_jmp_o,
   output logic           jtype_o,
   output logic           itype_o,
   output logic           movf_o,
   output logic           rd_mem_o,
   output logic           wr_mem_o,
   output logic           reg_write_o,
   output logic           branch_taken_o,
   output logic           is_ld_o,
   output logic           is_halt_o,
   output logic           is_cmp_o,
   output alu_op_t        alu_op_o
);

   logic [3:0] op;
   assign op = opcode_i[3:0];

   always_comb begin
      uncond_jmp_o   = 1'b0;
      jtype_o        = 1'b0;
      itype_o        = 1'b0;
      movf_o         = 1'b0;
      rd_mem_o       = 1'b0;
      wr_mem_o       = 1'b0;
      reg_write_o    = 1'b1;
      branch_taken_o = 1'b0;
      is_ld_o        = 1'b0;
      is_halt_o      = 1'b0;
      is_cmp_o       = 1'b0;
      alu_op_o       = ALU_ADD;
      case (op)
         OP_B:    begin uncond_jmp_o = 1'b1; jtype_o = 1'b1; branch_taken_o = 1'b1; reg_write_o = 1'b0; end
         OP_JEQ:  begin jtype_o = 1'b1; branch_taken_o = flag_z_i;  reg_write_o = 1'b0; end
         OP_JNE:  begin jtype_o = 1'b1; branch_taken_o = !flag_z_i; reg_write_o = 1'b0; end
         OP_JLT:  begin jtype_o = 1'b1; branch_taken_o = flag_n_i;  reg_write_o = 1'b0; end
         OP_JGE:  begin jtype_o = 1'b1; branch_taken_o = !flag_n_i; reg_write_o = 1'b0; end
         OP_ADD:  alu_op_o = ALU_ADD;
         OP_XOR:  alu_op_o = ALU_XOR;
         OP_STR:  begin wr_mem_o = 1'b1; reg_write_o = 1'b0; end
         OP_LD:   begin rd_mem_o = 1'b1; is_ld_o = 1'b1; end
         OP_SUB:  alu_op_o = ALU_SUB;
         OP_MOVF: movf_o = 1'b1;
`ifdef CTRL_SEQ_LSR_EN
         OP_LSR:  begin itype_o = 1'b1; alu_op_o = ALU_LSR; end
`else
         OP_LSR:  reg_write_o = 1'b0;
`endif
         OP_CMP:  begin alu_op_o = ALU_SUB; reg_write_o = 1'b0; is_cmp_o = 1'b1; end
         OP_LSL:  begin itype_o = 1'b1; alu_op_o = ALU_LSL; end
         OP_MOVI: begin itype_o = 1'b1; alu_op_o = ALU_PASS; end
         OP_HALT: begin is_halt_o = 1'b1; reg_write_o = 1'b0; end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_seq.sv
// Run/halt sequencer: FSM, registered compare flags and multi-cycle load wait around ctrl_decode.
// Opcode 1011 behaviour is selected by CTRL_SEQ_LSR_EN (see ctrl_decode).
module ctrl_seq
   import ctrl_pkg::*;
#(
   parameter int OPW     = 4,
   parameter int ALUOPW  = 3,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OPW-1:0]    opcode,
   input  logic              alu_zero,
   input  logic              alu_neg,
   output logic              pc_en,
   output logic              branch_taken,
   output logic              uncond_jmp,
   output logic              jtype,
   output logic              itype,
   output logic              movf,
   output logic              rd_mem,
   output logic              wr_mem,
   output logic              reg_write,
   output logic [ALUOPW-1:0] alu_op,
   output logic              done
);

   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   ctrl_state_t state_q, state_d;
   logic        flag_z_q, flag_z_d;
   logic        flag_n_q, flag_n_d;
   logic [3:0]  cnt_q, cnt_d;

   logic    dec_uj, dec_jt, dec_it, dec_mv, dec_rd, dec_wr, dec_rw, dec_bt;
   logic    dec_ld, dec_halt, dec_cmp;
   alu_op_t dec_alu;

   ctrl_decode #(.OPW(OPW)) u_decode (
      .opcode_i       (opcode),
      .flag_z_i       (flag_z_q),
      .flag_n_i       (flag_n_q),
      .uncond_jmp_o   (dec_uj),
      .jtype_o        (dec_jt),
      .itype_o        (dec_it),
      .movf_o         (dec_mv),
      .rd_mem_o       (dec_rd),
      .wr_mem_o       (dec_wr),
      .reg_write_o    (dec_rw),
      .branch_taken_o (dec_bt),
      .is_ld_o        (dec_ld),
      .is_halt_o      (dec_halt),
      .is_cmp_o       (dec_cmp),
      .alu_op_o       (dec_alu)
   );

   logic active, ld_final, ld_gate;

   assign active   = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
   // A load retires in its RUN cycle only when there is no wait phase.
   assign ld_final = ((state_q == ST_RUN) && (MEM_LAT == 1)) ||
                     ((state_q == ST_MEM_WAIT) && (cnt_q == LAT_LAST));
   assign ld_gate  = !dec_ld || ld_final;

   assign pc_en        = active && !dec_halt && ld_gate;
   assign reg_write    = active && dec_rw && ld_gate;
   assign branch_taken = active && dec_bt;
   assign uncond_jmp   = active && dec_uj;
   assign jtype        = active && dec_jt;
   assign itype        = active && dec_it;
   assign movf         = active && dec_mv;
   assign rd_mem       = active && dec_rd;
   assign wr_mem       = active && dec_wr;
   assign alu_op       = active ? ALUOPW'(dec_alu) : '0;
   assign done         = (state_q == ST_HALT);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      flag_z_d = flag_z_q;
      flag_n_d = flag_n_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = 4'd0;
            end
         end
         ST_RUN: begin
            cnt_d = 4'd0;
            if (dec_cmp) begin
               flag_z_d = alu_zero;
               flag_n_d = alu_neg;
            end
            if (dec_halt) begin
               state_d = ST_HALT;
            end else if (dec_ld && (MEM_LAT > 1)) begin
               state_d = ST_MEM_WAIT;
               cnt_d   = 4'd1;
            end
         end
         ST_MEM_WAIT: begin
            if (cnt_q == LAT_LAST) begin
               state_d = ST_RUN;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flag_z_q <= flag_z_d;
         flag_n_q <= flag_n_d;
      end
   end

endmodule
